// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and load sequencer for a shared WIDTH-bit register.
// Grants one requester at a time, captures its data into the register,
// pulses a one-cycle acknowledge, then waits HOLD idle cycles before the
// next grant can be issued.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                   clock_i,
  input  logic                   resetb_i,
  input  logic                   enable_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]       q_o,
  output logic                   busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Requests rotated so that position 0 is the requester at ptr; the first
  // set position is the round-robin winner.
  logic [PTR_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;
  logic [WIDTH-1:0] masked_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign cand_idx[gi]    = PTR_W'((int'(ptr_q) + gi) % N_REQ);
      assign cand_req[gi]    = req_i[cand_idx[gi]];
      // Only the granted requester's slice survives the mask.
      assign masked_data[gi] = data_i[gi*WIDTH +: WIDTH] & {WIDTH{grant_q[gi]}};
    end
  endgenerate

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [WIDTH-1:0] sel_data;

  // Pick the lowest rotated position with a request (reverse scan keeps the lowest).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
    win_oh = N_REQ'(1) << win_idx;
  end

  // OR together the masked slices to select the granted requester's data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  // Next-state and output logic for the IDLE/LOAD/HOLD sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    ack_d   = '0;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i && win_found) begin
          grant_d = win_oh;
          ptr_d   = PTR_W'((int'(win_idx) + 1) % N_REQ);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // The load completes regardless of req_i or enable_i.
        q_d     = sel_data;
        ack_d   = grant_q;
        cnt_d   = HOLD_CNT;
        state_d = (HOLD > 0) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign ack_o   = ack_q;
  assign q_o     = q_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter (N_REQ=4, WIDTH=8, HOLD=2).
module tb_shared_reg_arbiter;

  logic        clock_i;
  logic        resetb_i;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  grant_o;
  logic [3:0]  ack_o;
  logic [7:0]  q_o;
  logic        busy_o;

  int vectors;
  int miscompares;

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2)) dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .enable_i(enable_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .grant_o (grant_o),
    .ack_o   (ack_o),
    .q_o     (q_o),
    .busy_o  (busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0;
    enable_i = 1'b1;
    req_i    = 4'b0000;
    data_i   = 32'h0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if ({grant_o, ack_o, q_o, busy_o} !== 17'h0) begin
        miscompares++;
        $display("FAIL reset_hold: got grant=%b ack=%b q=%h busy=%b required all 0", grant_o, ack_o, q_o, busy_o);
      end
    end
    #14 resetb_i = 1'b1;  // released at 50 ns
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({grant_o, ack_o, q_o, busy_o} !== 17'h0) begin
        miscompares++;
        $display("FAIL reset_release: got grant=%b ack=%b q=%h busy=%b required all 0", grant_o, ack_o, q_o, busy_o);
      end
    end
    $display("reset: done, q=%h busy=%b", q_o, busy_o);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_q;
    data_i = 32'h13121110;
    req_i  = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001 << (t % 4);
      exp_q  = 8'h10 + 8'(t % 4);
      tick();
      vectors++;
      if (grant_o !== exp_oh || ack_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got grant=%b ack=%b required grant=%b ack=0000", t, grant_o, ack_o, exp_oh);
      end
      tick();
      vectors++;
      if (q_o !== exp_q || ack_o !== exp_oh || grant_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_load[%0d]: got q=%h ack=%b grant=%b required q=%h ack=%b grant=0000", t, q_o, ack_o, grant_o, exp_q, exp_oh);
      end
      tick();
      tick();
      vectors++;
      if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_hold[%0d]: got grant=%b busy=%b required grant=0000 busy=0", t, grant_o, busy_o);
      end
      $display("round_robin: txn %0d grant=%b q=%h", t, exp_oh, q_o);
    end
    req_i = 4'b0000;
  endtask

  task automatic test_single();
    // ptr is 1 here; requester 2 is the only one asking.
    data_i = 32'h00A50000;
    req_i  = 4'b0100;
    tick();
    vectors++;
    if (grant_o !== 4'b0100 || busy_o !== 1'b1 || ack_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_grant: got grant=%b busy=%b ack=%b required grant=0100 busy=1 ack=0000", grant_o, busy_o, ack_o);
    end
    tick();
    vectors++;
    if (q_o !== 8'hA5 || ack_o !== 4'b0100 || grant_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_load: got q=%h ack=%b grant=%b required q=a5 ack=0100 grant=0000", q_o, ack_o, grant_o);
    end
    req_i = 4'b0000;
    tick();
    vectors++;
    if (ack_o !== 4'b0000 || busy_o !== 1'b1 || q_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_hold: got ack=%b busy=%b q=%h required ack=0000 busy=1 q=a5", ack_o, busy_o, q_o);
    end
    tick();
    vectors++;
    if (busy_o !== 1'b0 || q_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b q=%h required busy=0 q=a5", busy_o, q_o);
    end
    $display("single: grant=0100 q=%h", q_o);
  endtask

  task automatic test_wrap_skip();
    data_i = 32'hD0C0B0A0;
    req_i  = 4'b1000;
    tick();
    vectors++;
    if (grant_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_grant3: got grant=%b required 1000", grant_o);
    end
    tick();
    vectors++;
    if (q_o !== 8'hD0 || ack_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_load3: got q=%h ack=%b required q=d0 ack=1000", q_o, ack_o);
    end
    req_i = 4'b0000;
    tick();
    tick();
    req_i = 4'b0010;
    tick();
    vectors++;
    if (grant_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL wrap_skip_grant: got grant=%b required 0010", grant_o);
    end
    tick();
    vectors++;
    if (q_o !== 8'hB0 || ack_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL wrap_skip_load: got q=%h ack=%b required q=b0 ack=0010", q_o, ack_o);
    end
    req_i = 4'b0000;
    tick();
    tick();
    $display("wrap_skip: grants 1000 then 0010, q=%h", q_o);
  endtask

  task automatic test_enable_gating();
    int bad;
    data_i   = 32'h0000005A;
    enable_i = 1'b0;
    req_i    = 4'b0001;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant_o !== 4'b0000 || busy_o !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL enable_block: got %0d cycles with grant/busy required 0", bad);
    end
    enable_i = 1'b1;
    tick();
    vectors++;
    if (grant_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL enable_grant: got grant=%b required 0001", grant_o);
    end
    enable_i = 1'b0;  // dropped during LOAD
    tick();
    vectors++;
    if (q_o !== 8'h5A || ack_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL enable_drop_load: got q=%h ack=%b required q=5a ack=0001", q_o, ack_o);
    end
    tick();
    tick();
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (grant_o !== 4'b0000 || busy_o !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL enable_drop_nogrant: got %0d cycles with grant/busy required 0", bad);
    end
    req_i    = 4'b0000;
    enable_i = 1'b1;
    $display("enable_gating: blocked 20 cycles, load q=%h completed", q_o);
  endtask

  task automatic test_reset_midop();
    // ptr is 1; requester 1 wins with data 3c while q still holds 5a.
    data_i = 32'h00003C77;
    req_i  = 4'b0010;
    tick();
    vectors++;
    if (grant_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL midop_grant: got grant=%b required 0010", grant_o);
    end
    resetb_i = 1'b0;
    #1;
    vectors++;
    if ({grant_o, ack_o, q_o, busy_o} !== 17'h0) begin
      miscompares++;
      $display("FAIL midop_async_clear: got grant=%b ack=%b q=%h busy=%b required all 0", grant_o, ack_o, q_o, busy_o);
    end
    tick();
    vectors++;
    if (q_o !== 8'h00 || ack_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_no_ack: got q=%h ack=%b required q=00 ack=0000", q_o, ack_o);
    end
    resetb_i = 1'b1;
    req_i    = 4'b1111;
    tick();
    vectors++;
    if (grant_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL midop_rearb: got grant=%b required 0001", grant_o);
    end
    tick();
    vectors++;
    if (q_o !== 8'h77 || ack_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL midop_reload: got q=%h ack=%b required q=77 ack=0001", q_o, ack_o);
    end
    req_i = 4'b0000;
    tick();
    tick();
    $display("reset_midop: aborted, re-arbitrated grant=0001 q=%h", q_o);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap_skip();
    test_enable_gating();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
